keypad_cmd_encoder: RTL
=======================

# keypad_cmd_encoder

Scans a 4x4 matrix keypad, synchronizes and debounces the column inputs, and encodes each accepted key press into a single-cycle 4-bit command on `cmd`. It is the input-side counterpart of the display path: its `cmd` output feeds the calculator core's `cmd` input directly. Between presses `cmd` holds the idle code.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per row slot; legal range ≥ 4.
- `DEBOUNCE_FRAMES`, default 4: number of consecutive identical frames required to accept a press, and also to accept a release; legal range ≥ 1.
- `REPEAT_FRAMES`, default 25: frames between auto-repeat emissions. Used only when `KEYPAD_REPEAT_EN` is defined.
- `clock  in  1`: system clock. This is the block's only clock.
- `reset  in  1`: synchronous, active-high reset.
- `col  in  4`: keypad columns, active-low (pulled up), asynchronous to `clock`.
- `row  out  4`: keypad row drive, active-low, one-hot-low.
- `cmd  out  4`: encoded command; non-idle for exactly one cycle per emission.
- `key_held  out  1`: high while a debounced key is held (states HELD and RELEASE).

## Operation
- Command codes:
  - 0x0–0x9: digits.
  - 0xA: add.
  - 0xB: subtract.
  - 0xC: multiply.
  - 0xD: equal.
  - 0xE: clear.
  - 0xF: idle.
- Key map, row r / col c:
  - r0: 1, 2, 3, A.
  - r1: 4, 5, 6, B.
  - r2: 7, 8, 9, C.
  - r3: `*`, 0, `#`, D.
  - Letters map to the same-named codes; `*` maps to 0xE and `#` maps to 0xD.
- `col` passes through a 2-flop synchronizer before any use.
- Scanner:
  - A row index 0..3 drives `row = ~(1<<idx)`. A slot counter counts 0..SCAN_DIV-1.
  - In the cycle where the slot counter equals SCAN_DIV-1, the synchronized `col` bits are sampled into that row's entry of a 16-bit snapshot, and then the row index advances (3 wraps to 0).
  - Completing the row-3 sample ends a frame and produces a one-cycle `frame_done` pulse.
- Frame classification: exactly one snapshot bit pressed gives SINGLE(k). Zero bits gives NONE. Two or more bits gives MULTI, which is treated as NONE in IDLE and DEBOUNCE and as "key still down" in HELD and RELEASE.
- The FSM advances only on `frame_done`. Counter `dcnt` counts frames.
  - IDLE: on SINGLE(k), set `cand`=k and `dcnt`=1, then go to DEBOUNCE. If DEBOUNCE_FRAMES=1, instead emit immediately and go to HELD.
  - DEBOUNCE:
    - SINGLE(`cand`): increment `dcnt`. When `dcnt` reaches DEBOUNCE_FRAMES, emit the code of `cand` and go to HELD.
    - Any other class: go to IDLE.
  - HELD: on NONE, set `dcnt`=1 and go to RELEASE. Otherwise stay in HELD.
  - RELEASE:
    - NONE: increment `dcnt`. On reaching DEBOUNCE_FRAMES, go to IDLE.
    - Anything else: go to HELD with no new emission.
- Emit means: `cmd` equals the code in the cycle after the `frame_done` that satisfied the condition, and returns to 0xF in the following cycle.
- A new key pressed while another is held produces no emission; the first key must be released and the release debounced first.
- Reset mid-operation: every register returns to its reset value on that edge, including any pending emission. A key still down after reset is treated as a new press and is emitted after a full debounce.

## Timing
- Reset values:
  - `row` = 4'b1110.
  - `cmd` = 4'hF.
  - `key_held` = 0.
  - Row index 0, slot counter 0.
  - Snapshot all-released, FSM in IDLE, `dcnt` = 0, `cand` = 0.
- Frame length: 4·SCAN_DIV cycles.
- Press-to-`cmd` latency: between DEBOUNCE_FRAMES and DEBOUNCE_FRAMES+1 frames (depending on press phase), plus 1 cycle.
- The synchronizer adds 2 cycles. This delay is absorbed because sampling occurs at slot end and SCAN_DIV ≥ 4.
- `cmd` is registered. No two emissions are closer together than one frame.

## Configuration
- `KEYPAD_REPEAT_EN` defined: in HELD, a repeat counter counts frames whose class is SINGLE(`cand`).
  - The code of `cand` is re-emitted every REPEAT_FRAMES such frames.
  - Any other class clears the counter.
  - Entering HELD from DEBOUNCE also clears the counter.
- `KEYPAD_REPEAT_EN` not defined: one emission per press. The repeat counter is not built and REPEAT_FRAMES is ignored.

## Structure
- Package `keypad_pkg` contains:
  - `cmd_t` command-code constants: CMD_IDLE=4'hF, CMD_ADD=4'hA, CMD_SUB=4'hB, CMD_MUL=4'hC, CMD_EQ=4'hD, CMD_CLR=4'hE.
  - The FSM state enum: IDLE, DEBOUNCE, HELD, RELEASE.
  - The key-map function from (row, col) to `cmd_t`.
- Sub-module `keypad_scan` contains the synchronizer, row driver, slot counter, snapshot, `frame_done`, and the one/none/multi classification. The top level holds the FSM and the `cmd` register.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_FRAMES=2, so a frame is 16 cycles.
- Reset: `reset`=1 for 2 cycles → `row`=1110, `cmd`=F, `key_held`=0. Afterwards `row` steps 1101, 1011, 0111, 1110 every 4 cycles.
- Press "5" (r1, c1), held for 5 frames, then released → exactly one `cmd`=0x5 pulse, 2–3 frames after press. `key_held` goes high with the pulse and drops 2 frames after release.
- Bounce: "7" pressed for 1 frame, released for 1 frame, then pressed for 3 frames → exactly one 0x7, emitted after the final stable press. Never two pulses.
- `*` then `#` (full press/release each) → 0xE then 0xD. Pressing "1" and "2" together for 4 frames → no emission.
- Hold "A"; after the 0xA emission, also press "3" while A is still held → no emission for 3; only one 0xA in total. With `KEYPAD_REPEAT_EN` and REPEAT_FRAMES=3, holding A for 10 frames → 0xA at acceptance, then every 3 frames.
- Assert `reset` during DEBOUNCE while "9" is held → no 0x9 before reset; `cmd`=F the cycle after reset. 0x9 is emitted after a full 2-frame debounce following reset release.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared command codes, FSM states, frame classes and the 4x4 key map for the keypad encoder.
package keypad_pkg;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_IDLE = 4'hF;
  localparam cmd_t CMD_ADD  = 4'hA;
  localparam cmd_t CMD_SUB  = 4'hB;
  localparam cmd_t CMD_MUL  = 4'hC;
  localparam cmd_t CMD_EQ   = 4'hD;
  localparam cmd_t CMD_CLR  = 4'hE;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_t;

  // '*' clears and '#' doubles as equal, same as the D key.
  function automatic cmd_t key_map(input logic [1:0] r, input logic [1:0] c);
    cmd_t code;
    case ({r, c})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = CMD_ADD;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = CMD_SUB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = CMD_MUL;
      4'hC:    code = CMD_CLR;
      4'hD:    code = 4'h0;
      4'hE:    code = CMD_EQ;
      4'hF:    code = CMD_EQ;
      default: code = CMD_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_cmd_encoder_scan.sv
// Row scanner: column synchronizer, row driver, slot counter, 16-key snapshot and frame classifier.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       frame_done,
  output logic [1:0] cls,
  output logic [3:0] key
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

  logic [3:0]    col_s1, col_s2;
  logic [1:0]    row_idx;
  logic [SW-1:0] slot;
  logic [15:0]   snap;
  logic          slot_end;
  logic [4:0]    nbits;

  assign slot_end = (slot == SLOT_LAST);
  assign row      = ~(4'b0001 << row_idx);

  // Sampling at slot end leaves the 2-cycle synchronizer delay well inside the slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_s1     <= 4'hF;
      col_s2     <= 4'hF;
      row_idx    <= 2'd0;
      slot       <= '0;
      snap       <= '0;
      frame_done <= 1'b0;
    end else begin
      col_s1     <= col;
      col_s2     <= col_s1;
      frame_done <= slot_end && (row_idx == 2'd3);
      if (slot_end) begin
        slot                        <= '0;
        row_idx                     <= row_idx + 2'd1;
        snap[{row_idx, 2'b00} +: 4] <= ~col_s2;
      end else begin
        slot <= slot + SW'(1);
      end
    end
  end

  // Snapshot bit r*4+c set means key (r,c) was seen pressed this frame.
  always_comb begin
    nbits = '0;
    key   = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) begin
        nbits = nbits + 5'd1;
        key   = 4'(i);
      end
    end
    if (nbits == 5'd0)      cls = CLS_NONE;
    else if (nbits == 5'd1) cls = CLS_SINGLE;
    else                    cls = CLS_MULTI;
  end

endmodule

// File: rtl/keypad_cmd_encoder.sv
// Keypad press/release debounce FSM and registered one-cycle command output.
// Optional auto-repeat while a key is held is built when KEYPAD_REPEAT_EN is defined.
module keypad_cmd_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] cmd,
  output logic       key_held
);

  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DF = DW'(DEBOUNCE_FRAMES);

  logic       frame_done;
  logic [1:0] cls_raw;
  logic [3:0] key;
  cls_t       cls;
  logic       same;

  state_t     state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [3:0] cand, cand_n;
  cmd_t       cmd_n;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] RF = RW'(REPEAT_FRAMES);
  logic [RW-1:0] rcnt, rcnt_n;
`else
  logic repeat_unused;
  assign repeat_unused = (REPEAT_FRAMES > 0);
`endif

  keypad_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clock      (clock),
    .reset      (reset),
    .col        (col),
    .row        (row),
    .frame_done (frame_done),
    .cls        (cls_raw),
    .key        (key)
  );

  assign cls      = cls_t'(cls_raw);
  assign same     = (cls == CLS_SINGLE) && (key == cand);
  assign key_held = (state == HELD) || (state == RELEASE);

  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    cand_n  = cand;
    cmd_n   = CMD_IDLE;
`ifdef KEYPAD_REPEAT_EN
    rcnt_n  = rcnt;
`endif
    if (frame_done) begin
      case (state)
        IDLE: begin
          if (cls == CLS_SINGLE) begin
            cand_n = key;
            dcnt_n = DW'(1);
            if (DEBOUNCE_FRAMES == 1) begin
              cmd_n   = key_map(key[3:2], key[1:0]);
              state_n = HELD;
`ifdef KEYPAD_REPEAT_EN
              rcnt_n  = '0;
`endif
            end else begin
              state_n = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (same) begin
            dcnt_n = dcnt + DW'(1);
            if (dcnt + DW'(1) == DF) begin
              cmd_n   = key_map(cand[3:2], cand[1:0]);
              state_n = HELD;
`ifdef KEYPAD_REPEAT_EN
              rcnt_n  = '0;
`endif
            end
          end else begin
            dcnt_n  = '0;
            state_n = IDLE;
          end
        end
        HELD: begin
          if (cls == CLS_NONE) begin
            dcnt_n = DW'(1);
            // A one-frame release filter accepts the release on this very frame.
            if (DEBOUNCE_FRAMES == 1) state_n = IDLE;
            else                      state_n = RELEASE;
          end
`ifdef KEYPAD_REPEAT_EN
          if (same) begin
            if (rcnt + RW'(1) == RF) begin
              cmd_n  = key_map(cand[3:2], cand[1:0]);
              rcnt_n = '0;
            end else begin
              rcnt_n = rcnt + RW'(1);
            end
          end else begin
            rcnt_n = '0;
          end
`endif
        end
        RELEASE: begin
          if (cls == CLS_NONE) begin
            dcnt_n = dcnt + DW'(1);
            if (dcnt + DW'(1) == DF) state_n = IDLE;
          end else begin
            state_n = HELD;
`ifdef KEYPAD_REPEAT_EN
            rcnt_n  = '0;
`endif
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      dcnt  <= '0;
      cand  <= '0;
      cmd   <= CMD_IDLE;
`ifdef KEYPAD_REPEAT_EN
      rcnt  <= '0;
`endif
    end else begin
      state <= state_n;
      dcnt  <= dcnt_n;
      cand  <= cand_n;
      cmd   <= cmd_n;
`ifdef KEYPAD_REPEAT_EN
      rcnt  <= rcnt_n;
`endif
    end
  end

endmodule
